// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared ALU/arbiter definitions. Holds the ALU-wide macros
//               (`WIDTH, opcode encodings, `ALU_OP_W, `ALU_ARB_CNT_W) and
//               the package constants derived from them. Opcode 0 is left
//               unused so that an idle mux selects the ALU default arm.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef ADD
`define ADD 5'd1
`endif
`ifndef SUB
`define SUB 5'd2
`endif
`ifndef MPY
`define MPY 5'd3
`endif
`ifndef ALU_OP_W
`define ALU_OP_W 5
`endif
`ifndef ALU_ARB_CNT_W
`define ALU_ARB_CNT_W 16
`endif

package alu_arbiter_pkg;
  localparam int c_OP_W   = `ALU_OP_W;
  localparam int c_DATA_W = `WIDTH;
  localparam int c_CNT_W  = `ALU_ARB_CNT_W;

  // Opcode driven to the ALU when nobody holds the grant.
  localparam logic [c_OP_W-1:0] c_OP_IDLE = '0;
endpackage

`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Request, ALU and response bundle of the ALU arbiter.
//               slave  = arbiter side, master = requesters/ALU/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
);
  import alu_arbiter_pkg::*;

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*c_OP_W-1:0]   req_opcode;
  logic [NREQ*c_DATA_W-1:0] req_a;
  logic [NREQ*c_DATA_W-1:0] req_b;
  logic [c_OP_W-1:0]        alu_opcode;
  logic [c_DATA_W-1:0]      alu_a;
  logic [c_DATA_W-1:0]      alu_b;
  logic [c_DATA_W-1:0]      alu_z;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [c_DATA_W-1:0]      rsp_data;
  logic [ID_W-1:0]          rsp_id;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_z, rsp_ready,
    output req_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_z, rsp_ready,
    input  req_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_data, rsp_id
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches last+1 .. last+NREQ
//               (mod NREQ) and returns the first valid requester as a one-hot
//               grant (gated by en_i) plus its encoded index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  wire logic [NREQ-1:0] req_i,
  input  wire logic [ID_W-1:0] last_i,
  input  wire logic            en_i,
  output logic      [NREQ-1:0] grant_o,
  output logic      [ID_W-1:0] idx_o
);
  logic hi_found;
  int   hi_idx;
  int   lo_idx;
  int   win;

  // Lowest valid index above last (wrap-free hit) and lowest valid overall (wrap hit).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = 0;
    lo_idx   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = i;
        if (i > int'(last_i)) begin
          hi_found = 1'b1;
          hi_idx   = i;
        end
      end
    end
  end

  assign win     = hi_found ? hi_idx : lo_idx;
  assign idx_o   = ID_W'(win);
  assign grant_o = (en_i && (|req_i)) ? (NREQ'(1) << win) : '0;
endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU between NREQ requesters.
//               Round-robin grant, operand/opcode mux toward the ALU and a
//               single registered response slot with valid/ready handshake.
//               Optional build macro ALU_ARB_STATS_EN adds grant_cnt, one
//               saturating per-requester grant counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  alu_arbiter_if.slave      bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ*c_CNT_W-1:0] grant_cnt
`endif
);
  logic                rsp_valid_q, rsp_valid_d;
  logic [c_DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
  logic [ID_W-1:0]     last_q,      last_d;

  logic                can_accept;
  logic [NREQ-1:0]     grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  int                  sel;

  // Slot can take a result if empty or draining this edge; reset blocks grants.
  assign can_accept = (!rsp_valid_q || bus.rsp_ready) && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr (
    .req_i   (bus.req_valid),
    .last_i  (last_q),
    .en_i    (can_accept),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  assign grant_any     = |grant;
  assign bus.req_ready = grant;

  // Steer the granted requester onto the ALU; zeros select its default arm when idle.
  always_comb begin
    bus.alu_opcode = c_OP_IDLE;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    sel            = int'(grant_idx);
    if (grant_any) begin
      bus.alu_opcode = bus.req_opcode[sel*c_OP_W +: c_OP_W];
      bus.alu_a      = bus.req_a[sel*c_DATA_W +: c_DATA_W];
      bus.alu_b      = bus.req_b[sel*c_DATA_W +: c_DATA_W];
    end
  end

  // Response slot: load on grant (also covers drain+reload), else empty on drain.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    last_d      = last_q;
    if (grant_any) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = bus.alu_z;
      rsp_id_d    = grant_idx;
      last_d      = grant_idx;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers; pointer resets to the top index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      last_q      <= ID_W'(NREQ - 1);
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      last_q      <= last_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
  logic [NREQ-1:0][c_CNT_W-1:0] cnt_q, cnt_d;

  // Count grants per requester, sticking at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i] && (cnt_q[i] != {c_CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + c_CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`endif
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a scoreboard of
//               expected responses and a behavioural ALU on the alu_* pins.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int ID_W = 1;

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [c_DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [NREQ*c_CNT_W-1:0] grant_cnt;
`endif

  alu_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // Behavioural shared ALU; unknown opcodes give zero.
  always_comb begin
    bus.alu_z = '0;
    case (bus.alu_opcode)
      `ADD:    bus.alu_z = bus.alu_a + bus.alu_b;
      `SUB:    bus.alu_z = bus.alu_a - bus.alu_b;
      `MPY:    bus.alu_z = bus.alu_a * bus.alu_b;
      default: bus.alu_z = '0;
    endcase
  end

  task automatic set_req(input int i, input logic [c_OP_W-1:0] op,
                         input logic [c_DATA_W-1:0] a, input logic [c_DATA_W-1:0] b);
    bus.req_opcode[i*c_OP_W +: c_OP_W]     = op;
    bus.req_a[i*c_DATA_W +: c_DATA_W]      = a;
    bus.req_b[i*c_DATA_W +: c_DATA_W]      = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_rsp: got v=%0b id=%0d d=%0d want v=0 id=0 d=0", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    n_tests++;
    if ({bus.req_ready, bus.alu_opcode, bus.alu_a, bus.alu_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle_mux: got rdy=%b op=%0d a=%0d b=%0d want all 0", bus.req_ready, bus.alu_opcode, bus.alu_a, bus.alu_b);
    end
    bus.req_valid = 2'b11;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_blocks_grant: got req_ready=%b want 00", bus.req_ready);
    end
    bus.req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_rsp_valid: got %0b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    set_req(0, `ADD, 16'd5, 16'd7);
    bus.req_valid = 2'b01;
    #1;
    n_tests++;
    if ({bus.req_ready, bus.alu_opcode, bus.alu_a, bus.alu_b} !== {2'b01, `ADD, 16'd5, 16'd7}) begin
      n_fail++;
      $display("FAIL single_grant: got rdy=%b op=%0d a=%0d b=%0d want rdy=01 op=%0d a=5 b=7",
               bus.req_ready, bus.alu_opcode, bus.alu_a, bus.alu_b, `ADD);
    end
    sb.push_back({1'b0, 16'd12});
    @(negedge clk);
    bus.req_valid = '0;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL single_rsp: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, e.id, e.data}) begin
        n_fail++;
        $display("FAIL single_rsp: got v=%0b id=%0d d=%0d want v=1 id=%0d d=%0d", bus.rsp_valid, bus.rsp_id, bus.rsp_data, e.id, e.data);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_data, bus.req_ready, bus.alu_opcode} !== {1'b0, 16'd12, 2'b00, 5'd0}) begin
      n_fail++;
      $display("FAIL single_drain: got v=%0b d=%0d rdy=%b op=%0d want v=0 d=12 rdy=00 op=0",
               bus.rsp_valid, bus.rsp_data, bus.req_ready, bus.alu_opcode);
    end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] exp_rdy;
    rst = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, `SUB, 16'd10, 16'd3);
    set_req(1, `MPY, 16'd4, 16'd6);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_tests++;
      if (bus.req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL contention_grant[%0d]: got %b want %b", k, bus.req_ready, exp_rdy);
      end
      if (k % 2 == 0) sb.push_back({1'b0, 16'd7});
      else            sb.push_back({1'b1, 16'd24});
      @(negedge clk);
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL contention_rsp[%0d]: scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, e.id, e.data}) begin
          n_fail++;
          $display("FAIL contention_rsp[%0d]: got v=%0b id=%0d d=%0d want v=1 id=%0d d=%0d",
                   k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, e.id, e.data);
        end
      end
    end
    bus.req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_drain: got rsp_valid=%0b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b1;
    set_req(0, `ADD, 16'd5, 16'd7);
    bus.req_valid = 2'b01;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_first_grant: got %b want 01", bus.req_ready);
    end
    sb.push_back({1'b0, 16'd12});
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready} !== {1'b1, 1'b0, 16'd12, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%0b id=%0d d=%0d rdy=%b want v=1 id=0 d=12 rdy=00",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_reload_grant: got %b want 10", bus.req_ready);
    end
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL bp_rsp0: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, e.id, e.data}) begin
        n_fail++;
        $display("FAIL bp_rsp0: got v=%0b id=%0d d=%0d want v=1 id=%0d d=%0d", bus.rsp_valid, bus.rsp_id, bus.rsp_data, e.id, e.data);
      end
    end
    sb.push_back({1'b1, 16'd24});
    @(negedge clk);
    bus.req_valid = '0;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL bp_rsp1: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, e.id, e.data}) begin
        n_fail++;
        $display("FAIL bp_rsp1: got v=%0b id=%0d d=%0d want v=1 id=%0d d=%0d", bus.rsp_valid, bus.rsp_id, bus.rsp_data, e.id, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    // Leave a response from requester 1 in the slot, then reset over it.
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b10;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_pre_grant: got %b want 10", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b1, 16'd24}) begin
      n_fail++;
      $display("FAIL rstmid_pending: got v=%0b id=%0d d=%0d want v=1 id=1 d=24", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    sb.delete();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_ready: got %b want 00", bus.req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL rstmid_discard: got v=%0b id=%0d d=%0d want v=0 id=0 d=0", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_first_grant: got %b want 01", bus.req_ready);
    end
    // Requester 0 now owns the pointer; a reset must hand priority back to 0.
    @(negedge clk);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_ptr_reset: got %b want 01", bus.req_ready);
    end
    sb.push_back({1'b0, 16'd12});
    @(negedge clk);
    bus.req_valid = '0;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL rstmid_rsp: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, e.id, e.data}) begin
        n_fail++;
        $display("FAIL rstmid_rsp: got v=%0b id=%0d d=%0d want v=1 id=%0d d=%0d", bus.rsp_valid, bus.rsp_id, bus.rsp_data, e.id, e.data);
      end
    end
    @(negedge clk);
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (grant_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset: got %h want 0", grant_cnt);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    repeat (4) @(negedge clk);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = '0;
    n_tests++;
    if (grant_cnt !== {16'd2, 16'd3}) begin
      n_fail++;
      $display("FAIL stats_count: got %h want 00020003", grant_cnt);
    end
    force dut.cnt_q = {16'd2, 16'hFFFF};
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = '0;
    release dut.cnt_q;
    #1;
    n_tests++;
    if (grant_cnt !== {16'd2, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL stats_saturate: got %h want 0002ffff", grant_cnt);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
